// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect capture across memory waits,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stallF,
   input  logic        stallD,
   input  logic        flushD,
   input  logic        pcsrcD,
   input  logic [31:0] pcbranchD,
   input  logic        jumpD,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] imem_addr,
   output logic [31:0] pcF,
   output logic [31:0] instrD,
   output logic [31:0] pcplus4D,
   output logic        validD,
   output logic        imem_wait
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        pending_q, pending_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pcplus4_q, pcplus4_d;
   logic        valid_q, valid_d;

   logic [31:0] pcplus4F;
   logic [31:0] jump_target;
   logic [31:0] live_target;
   logic        live_redirect;
   logic        advance;

   assign pcplus4F      = pc_q + 32'd4;
   assign jump_target   = {pcplus4_q[31:28], instr_q[25:0], 2'b00};
   assign advance       = !stallF && imem_ready;
   assign live_redirect = jumpD || pcsrcD;
   // Jump wins over a simultaneous branch.
   assign live_target   = jumpD ? jump_target : pcbranchD;

   // PC and the single outstanding redirect slot.
   always_comb begin
      pc_d          = pc_q;
      pending_d     = pending_q;
      redirect_pc_d = redirect_pc_q;
      if (advance) begin
         pending_d = 1'b0;
         if (live_redirect) begin
            pc_d = live_target;
         end else if (pending_q) begin
            pc_d = redirect_pc_q;
         end else begin
            pc_d = pcplus4F;
         end
      end else if (live_redirect) begin
         pending_d     = 1'b1;
         redirect_pc_d = live_target;
      end
   end

   // IF/ID register; a word fetched while a redirect is pending is wrong-path.
   always_comb begin
      instr_d   = instr_q;
      pcplus4_d = pcplus4_q;
      valid_d   = valid_q;
      if (stallD) begin
         instr_d   = instr_q;
         pcplus4_d = pcplus4_q;
         valid_d   = valid_q;
      end else if (flushD || !imem_ready || pending_q) begin
         instr_d   = 32'd0;
         pcplus4_d = 32'd0;
         valid_d   = 1'b0;
      end else begin
         instr_d   = imem_rdata;
         pcplus4_d = pcplus4F;
         valid_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         pending_q     <= 1'b0;
         redirect_pc_q <= 32'd0;
         instr_q       <= 32'd0;
         pcplus4_q     <= 32'd0;
         valid_q       <= 1'b0;
      end else begin
         pc_q          <= pc_d;
         pending_q     <= pending_d;
         redirect_pc_q <= redirect_pc_d;
         instr_q       <= instr_d;
         pcplus4_q     <= pcplus4_d;
         valid_q       <= valid_d;
      end
   end

   assign pcF       = pc_q;
   assign imem_addr = pc_q;
   assign instrD    = instr_q;
   assign pcplus4D  = pcplus4_q;
   assign validD    = valid_q;
   assign imem_wait = !imem_ready;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: the driver queues the expected post-edge state
// for each cycle, an independent monitor pops and compares it after the edge.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset, stallF, stallD, flushD, pcsrcD, jumpD, imem_ready;
   logic [31:0] pcbranchD, imem_rdata;
   logic [31:0] imem_addr, pcF, instrD, pcplus4D;
   logic        validD, imem_wait;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] p4;
      logic        v;
      logic        wt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   items  = 0;

   always #5 clk = ~clk;

   fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .stallF     (stallF),
      .stallD     (stallD),
      .flushD     (flushD),
      .pcsrcD     (pcsrcD),
      .pcbranchD  (pcbranchD),
      .jumpD      (jumpD),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .pcF        (pcF),
      .instrD     (instrD),
      .pcplus4D   (pcplus4D),
      .validD     (validD),
      .imem_wait  (imem_wait)
   );

   // Memory image: addr ^ 0xDEAD_0000, with a J-type word planted at 0x1000_0004.
   always_comb begin
      if (imem_addr == 32'h1000_0004) imem_rdata = 32'h0800_0040;
      else                            imem_rdata = imem_addr ^ 32'hDEAD_0000;
   end

   task automatic chk32(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s item %0d: got %h expected %h", name, idx, act, req);
      end
   endtask

   // Monitor: compares the DUT state after every edge that has an expectation queued.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            items++;
            chk32("pcF", items, pcF, e.pc);
            chk32("imem_addr", items, imem_addr, e.pc);
            chk32("instrD", items, instrD, e.instr);
            chk32("pcplus4D", items, pcplus4D, e.p4);
            chk32("validD", items, {31'd0, validD}, {31'd0, e.v});
            chk32("imem_wait", items, {31'd0, imem_wait}, {31'd0, e.wt});
         end
      end
   end

   task automatic step(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] pb, input logic j,
                       input logic rdy, input logic [31:0] e_pc, input logic [31:0] e_in,
                       input logic [31:0] e_p4, input logic e_v);
      exp_t e;
      reset      = r;
      stallF     = sf;
      stallD     = sd;
      flushD     = fd;
      pcsrcD     = ps;
      pcbranchD  = pb;
      jumpD      = j;
      imem_ready = rdy;
      @(posedge clk);
      e.pc    = e_pc;
      e.instr = e_in;
      e.p4    = e_p4;
      e.v     = e_v;
      e.wt    = !rdy;
      exp_q.push_back(e);
      #3;
   endtask

   initial begin
      int guard;
      //   rst sF sD fD ps pbranch        j  rdy  pcF            instrD         pcplus4D     v
      // Reset with stalls and a redirect live: reset wins.
      step(1, 1, 1, 1, 1, 32'h0000_0900, 1, 1, 32'h0000_0000, 32'h0, 32'h0, 0);
      step(1, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0000, 32'h0, 32'h0, 0);
      // Sequential fetch.
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0004, 32'hDEAD_0000, 32'h0000_0004, 1);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0008, 32'hDEAD_0004, 32'h0000_0008, 1);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_000C, 32'hDEAD_0008, 32'h0000_000C, 1);
      // Taken branch with flush in the advance cycle.
      step(0, 0, 0, 1, 1, 32'h0000_0100, 0, 1, 32'h0000_0100, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0104, 32'hDEAD_0100, 32'h0000_0104, 1);
      // Stall everything with flush: nothing moves.
      step(0, 1, 1, 1, 0, 32'h0, 0, 1, 32'h0000_0104, 32'hDEAD_0100, 32'h0000_0104, 1);
      // Branch during a two-cycle memory wait is remembered.
      step(0, 0, 0, 0, 1, 32'h0000_0200, 0, 0, 32'h0000_0104, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0000_0104, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0200, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0204, 32'hDEAD_0200, 32'h0000_0204, 1);
      // stallD with flushD: IF/ID holds while PC advances.
      step(0, 0, 1, 1, 0, 32'h0, 0, 1, 32'h0000_0208, 32'hDEAD_0200, 32'h0000_0204, 1);
      // Later redirect overwrites an earlier pending one.
      step(0, 0, 0, 0, 1, 32'h0000_0300, 0, 0, 32'h0000_0208, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 1, 32'h0000_0400, 0, 0, 32'h0000_0208, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0400, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0404, 32'hDEAD_0400, 32'h0000_0404, 1);
      // Jump beats a simultaneous branch.
      step(0, 0, 0, 1, 1, 32'h1000_0004, 0, 1, 32'h1000_0004, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h1000_0008, 32'h0800_0040, 32'h1000_0008, 1);
      step(0, 0, 0, 1, 1, 32'h0000_0500, 1, 1, 32'h1000_0100, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h1000_0104, 32'hCEAD_0100, 32'h1000_0104, 1);
      // stallF with a live branch: stored, then taken on the next advance.
      step(0, 1, 1, 0, 1, 32'h0000_0600, 0, 1, 32'h1000_0104, 32'hCEAD_0100, 32'h1000_0104, 1);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0600, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0604, 32'hDEAD_0600, 32'h0000_0604, 1);
      // PC+4 wraps at the top of the address space.
      step(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0000, 32'h2152_FFFC, 32'h0000_0000, 1);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0004, 32'hDEAD_0000, 32'h0000_0004, 1);
      // Reset mid-wait drops the pending redirect.
      step(0, 0, 0, 0, 1, 32'h0000_0700, 0, 0, 32'h0000_0004, 32'h0, 32'h0, 0);
      step(1, 1, 1, 0, 1, 32'h0000_0800, 0, 0, 32'h0000_0000, 32'h0, 32'h0, 0);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0004, 32'hDEAD_0000, 32'h0000_0004, 1);
      step(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'h0000_0008, 32'hDEAD_0004, 32'h0000_0008, 1);

      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #5;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
